// File: rtl/ram_arbiter.sv
// Two-master arbiter for the single-port data RAM: fixed priority to master 0,
// starvation guard for master 1, lock for master 0 atomic sequences.
module ram_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk_i,
  input  logic                n_rst_i,
  input  logic                m0_req_i,
  input  logic                m0_we_i,
  input  logic [DATA_W/8-1:0] m0_sel_i,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  input  logic                m0_lock_i,
  output logic                m0_gnt_o,
  output logic                m0_rvalid_o,
  output logic [DATA_W-1:0]   m0_rdata_o,
  input  logic                m1_req_i,
  input  logic                m1_we_i,
  input  logic [DATA_W/8-1:0] m1_sel_i,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  output logic                m1_gnt_o,
  output logic                m1_rvalid_o,
  output logic [DATA_W-1:0]   m1_rdata_o,
  output logic                ram_ce_o,
  output logic                ram_we_o,
  output logic [DATA_W/8-1:0] ram_sel_o,
  output logic [ADDR_W-1:0]   ram_addr_o,
  output logic [DATA_W-1:0]   ram_data_o,
  input  logic [DATA_W-1:0]   ram_data_i
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic {ARB, LOCK0} state_t;

  state_t     state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic       gnt0, gnt1;

  // Grants are gated by reset so the RAM bus stays idle while in reset.
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    state_d = state_q;
    if (n_rst_i) begin
      unique case (state_q)
        ARB: begin
          if (m0_req_i && m1_req_i) begin
            if (starve_q == STARVE_LIM) gnt1 = 1'b1;
            else                        gnt0 = 1'b1;
          end else begin
            gnt0 = m0_req_i;
            gnt1 = m1_req_i;
          end
          if (gnt0 && m0_lock_i) state_d = LOCK0;
        end
        LOCK0: begin
          gnt0 = m0_req_i;
          if (!m0_lock_i || !m0_req_i) state_d = ARB;
        end
        default: state_d = ARB;
      endcase
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!m1_req_i || gnt1)          starve_d = '0;
    else if (starve_q < STARVE_LIM) starve_d = starve_q + 4'd1;
  end

  assign m0_gnt_o = gnt0;
  assign m1_gnt_o = gnt1;

  always_comb begin
    ram_ce_o   = 1'b0;
    ram_we_o   = 1'b0;
    ram_sel_o  = '0;
    ram_addr_o = '0;
    ram_data_o = '0;
    if (gnt0) begin
      ram_ce_o   = 1'b1;
      ram_we_o   = m0_we_i;
      ram_sel_o  = m0_sel_i;
      ram_addr_o = m0_addr_i;
      ram_data_o = m0_wdata_i;
    end else if (gnt1) begin
      ram_ce_o   = 1'b1;
      ram_we_o   = m1_we_i;
      ram_sel_o  = m1_sel_i;
      ram_addr_o = m1_addr_i;
      ram_data_o = m1_wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q     <= ARB;
      starve_q    <= '0;
      m0_rvalid_o <= 1'b0;
      m1_rvalid_o <= 1'b0;
      m0_rdata_o  <= '0;
      m1_rdata_o  <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      m0_rvalid_o <= gnt0 && !m0_we_i;
      m1_rvalid_o <= gnt1 && !m1_we_i;
      if (gnt0 && !m0_we_i) m0_rdata_o <= ram_data_i;
      if (gnt1 && !m1_we_i) m1_rdata_o <= ram_data_i;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: directed accesses push expected read data,
// a negedge monitor pops and compares on every rvalid.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_ce, ram_we;
  logic [3:0]  ram_sel;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  logic        b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid, b_ram_ce, b_ram_we;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_ram_addr, b_ram_wdata;
  logic [3:0]  b_ram_sel;
  logic [31:0] b_ram_rdata = '0;

  logic [31:0] mem [256];
  logic [31:0] q0[$], q1[$];
  int unsigned checks = 0, errors = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk_i(clk), .n_rst_i(n_rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_sel_i(m0_sel), .m0_addr_i(m0_addr),
    .m0_wdata_i(m0_wdata), .m0_lock_i(m0_lock), .m0_gnt_o(m0_gnt),
    .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_sel_i(m1_sel), .m1_addr_i(m1_addr),
    .m1_wdata_i(m1_wdata), .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
    .ram_ce_o(ram_ce), .ram_we_o(ram_we), .ram_sel_o(ram_sel), .ram_addr_o(ram_addr),
    .ram_data_o(ram_wdata), .ram_data_i(ram_rdata)
  );

  ram_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(1)) dut_s1 (
    .clk_i(clk), .n_rst_i(n_rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_sel_i(m0_sel), .m0_addr_i(m0_addr),
    .m0_wdata_i(m0_wdata), .m0_lock_i(m0_lock), .m0_gnt_o(b_m0_gnt),
    .m0_rvalid_o(b_m0_rvalid), .m0_rdata_o(b_m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_sel_i(m1_sel), .m1_addr_i(m1_addr),
    .m1_wdata_i(m1_wdata), .m1_gnt_o(b_m1_gnt), .m1_rvalid_o(b_m1_rvalid), .m1_rdata_o(b_m1_rdata),
    .ram_ce_o(b_ram_ce), .ram_we_o(b_ram_we), .ram_sel_o(b_ram_sel), .ram_addr_o(b_ram_addr),
    .ram_data_o(b_ram_wdata), .ram_data_i(b_ram_rdata)
  );

  // Behavioural RAM: combinational read, byte-masked write at the grant edge.
  assign ram_rdata = mem[ram_addr[9:2]];
  always @(posedge clk) begin
    if (ram_ce && ram_we)
      for (int b = 0; b < 4; b++)
        if (ram_sel[b]) mem[ram_addr[9:2]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m0_rvalid) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL m0_rvalid: got 1 expected 0 (no read outstanding) at %0t", $time);
      end else chk("m0_rdata", m0_rdata, q0.pop_front());
    end
    if (m1_rvalid) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL m1_rvalid: got 1 expected 0 (no read outstanding) at %0t", $time);
      end else chk("m1_rdata", m1_rdata, q1.pop_front());
    end
  end

  task automatic access(input bit mst, input logic we, input logic [3:0] sel,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] exp);
    bit got = 1'b0;
    if (!mst) begin m0_req = 1; m0_we = we; m0_sel = sel; m0_addr = addr; m0_wdata = wdata; end
    else      begin m1_req = 1; m1_we = we; m1_sel = sel; m1_addr = addr; m1_wdata = wdata; end
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = mst ? m1_gnt : m0_gnt;
      if (!got) begin @(posedge clk); #1; end
    end
    chk(mst ? "m1_gnt_wait" : "m0_gnt_wait", 32'(got), 32'd1);
    if (got && !we) begin
      if (!mst) q0.push_back(exp); else q1.push_back(exp);
    end
    @(posedge clk); #1;
    if (!mst) m0_req = 0; else m1_req = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | 32'(i);
    n_rst = 0; m0_lock = 0;
    m0_req = 1; m0_we = 0; m0_sel = 4'hF; m0_addr = 32'h20; m0_wdata = '0;
    m1_req = 1; m1_we = 0; m1_sel = 4'hF; m1_addr = 32'h30; m1_wdata = '0;

    // Reset with both masters requesting
    repeat (2) @(negedge clk);
    chk("rst_m0_gnt", 32'(m0_gnt), 0);
    chk("rst_m1_gnt", 32'(m1_gnt), 0);
    chk("rst_ram_ce", 32'(ram_ce), 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    chk("rst_m1_rdata", m1_rdata, 0);
    @(posedge clk); #1; n_rst = 1;
    @(negedge clk);
    chk("first_m0_gnt", 32'(m0_gnt), 1);
    chk("first_m1_gnt", 32'(m1_gnt), 0);
    chk("first_ram_ce", 32'(ram_ce), 1);
    chk("first_ram_addr", ram_addr, 32'h20);
    q0.push_back(32'hA500_0008);
    @(posedge clk); #1; m0_req = 0;
    @(negedge clk);
    chk("second_m1_gnt", 32'(m1_gnt), 1);
    chk("second_ram_addr", ram_addr, 32'h30);
    q1.push_back(32'hA500_000C);
    @(posedge clk); #1; m1_req = 0;

    // Write by m0, read-after-write by m1 the next cycle, then byte-lane write
    access(0, 1, 4'hF, 32'h10, 32'hDEAD_BEEF, '0);
    access(1, 0, 4'hF, 32'h10, '0, 32'hDEAD_BEEF);
    access(0, 1, 4'b0100, 32'h10, 32'h00AB_0000, '0);
    access(0, 0, 4'hF, 32'h10, '0, 32'hDEAB_BEEF);
    access(0, 0, 4'hF, 32'h20, '0, 32'hA500_0008);
    access(0, 0, 4'hF, 32'h14, '0, 32'hA500_0005);
    @(posedge clk); #1;

    // Continuous dual requests: 4:1 pattern at STARVE_MAX=4, alternating at STARVE_MAX=1
    m0_req = 1; m0_we = 0; m0_addr = 32'h20; m1_req = 1; m1_we = 0; m1_addr = 32'h30;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("starve_m0_gnt", 32'(m0_gnt), 32'(i % 5 != 4));
      chk("starve_m1_gnt", 32'(m1_gnt), 32'(i % 5 == 4));
      chk("s1_m1_gnt", 32'(b_m1_gnt), 32'(i % 2 == 1));
      chk("s1_m0_gnt", 32'(b_m0_gnt), 32'(i % 2 == 0));
      if (i % 5 == 4) q1.push_back(32'hA500_000C); else q0.push_back(32'hA500_0008);
      @(posedge clk); #1;
    end
    m0_req = 0; m1_req = 0;
    @(posedge clk); #1;

    // Lock held 8 cycles against a waiting m1, then dropped with starve_cnt saturated
    m0_req = 1; m1_req = 1;
    for (int i = 0; i < 10; i++) begin
      m0_lock = (i < 8);
      @(negedge clk);
      chk("lock_m0_gnt", 32'(m0_gnt), 32'(i != 9));
      chk("lock_m1_gnt", 32'(m1_gnt), 32'(i == 9));
      if (i == 9) q1.push_back(32'hA500_000C); else q0.push_back(32'hA500_0008);
      @(posedge clk); #1;
    end
    m0_req = 0; m1_req = 0; m0_lock = 0;
    repeat (2) begin @(posedge clk); #1; end

    // Reset the cycle after a granted read: pending rvalid is dropped
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    @(negedge clk);
    chk("rstrd_m0_gnt", 32'(m0_gnt), 1);
    @(posedge clk); #1;
    n_rst = 0; m0_req = 0; q0.delete();
    #1;
    chk("rstrd_rvalid", 32'(m0_rvalid), 0);
    chk("rstrd_rdata", m0_rdata, 0);
    repeat (2) @(posedge clk);
    #1; n_rst = 1;
    repeat (4) @(posedge clk);
    @(negedge clk);

    chk("q0_drained", 32'(q0.size()), 0);
    chk("q1_drained", 32'(q1.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
